// File: rtl/vcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vcu_pkg
// Purpose  : Shared definitions for the vcu compute unit and its issue
//            front-end: default instruction width and issuer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package vcu_pkg;

    // Instruction width shared by vcu and vcu_insn_issuer.
    localparam int VCU_INSN_WIDTH = 128;

    // Issuer sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIRE = 2'd2,
        ST_WAIT = 2'd3
    } issuer_state_e;

endpackage
`default_nettype wire

// File: rtl/vcu_insn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vcu_insn_fifo
// Purpose  : Synchronous FIFO holding queued instructions for the issuer.
//            Head data is presented combinationally on rdata.
// Ports    : clk, rst (async, active-high)
//            wdata/push  - enqueue (ignored when full or flushing)
//            pop         - dequeue (ignored when empty or flushing)
//            flush       - empty the FIFO on the next edge
//            rdata       - current head entry
//            level       - occupancy 0..DEPTH; full/empty flags
// Revision : 1.0 - initial release
// ============================================================================
module vcu_insn_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A flush cycle suppresses both a push and a pop.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; level
    // carries one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/vcu_insn_issuer.sv
`default_nettype none
// ============================================================================
// Module   : vcu_insn_issuer
// Purpose  : Queued instruction issue front-end for vcu. Instructions are
//            enqueued over a valid/ready port and issued one at a time:
//            IDLE -> LOAD (pop, register insn) -> FIRE (work_en pulse)
//            -> WAIT (until vcu_done or timeout).
// Ports    : clk, rst (async, active-high)
//            insn_in/insn_in_valid/insn_in_ready - enqueue port
//            start      - level enable for new issues
//            flush      - discard queued (not in-flight) instructions
//            timeout_cycles/clear_err/timeout_err - WAIT watchdog
//            insn/work_en/vcu_done - vcu handshake
//            busy, level, done_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module vcu_insn_issuer
    import vcu_pkg::*;
#(
    parameter int INSN_WIDTH    = VCU_INSN_WIDTH,
    parameter int DEPTH         = 8,
    parameter int TIMEOUT_WIDTH = 24,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSN_WIDTH-1:0]    insn_in,
    input  logic                     insn_in_valid,
    output logic                     insn_in_ready,
    input  logic                     start,
    input  logic                     flush,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                     clear_err,
    output logic [INSN_WIDTH-1:0]    insn,
    output logic                     work_en,
    input  logic                     vcu_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]     done_cnt,
    output logic                     timeout_err
);

    issuer_state_e            state;
    issuer_state_e            state_nx;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [INSN_WIDTH-1:0]    fifo_head;
    logic                     push;
    logic                     issue;
    logic                     timeout_hit;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

    assign insn_in_ready = !fifo_full && !flush;
    assign push          = insn_in_valid && insn_in_ready;
    assign issue         = (state == ST_IDLE) && start && !fifo_empty
                           && !timeout_err && !flush;
    assign busy          = (state != ST_IDLE);

    // tmo_cnt holds the number of WAIT cycles elapsed including the
    // current one, so equality means the whole budget has been spent.
    assign timeout_hit   = (timeout_cycles != '0) && (tmo_cnt == timeout_cycles);

    vcu_insn_fifo #(
        .WIDTH (INSN_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (insn_in),
        .push  (push),
        .pop   (issue),
        .flush (flush),
        .rdata (fifo_head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        work_en  = 1'b0;
        case (state)
            ST_IDLE: if (issue) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_FIRE;
            ST_FIRE: begin
                work_en  = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: if (vcu_done || timeout_hit) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn        <= '0;
            tmo_cnt     <= '0;
            done_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // insn keeps the last issued instruction until the next pop.
            if (issue) insn <= fifo_head;

            if (state == ST_FIRE)      tmo_cnt <= TIMEOUT_WIDTH'(1);
            else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

            if (state == ST_WAIT && vcu_done) done_cnt <= done_cnt + 1'b1;

            // Completion beats a coincident timeout; a new error beats clear.
            if (state == ST_WAIT && !vcu_done && timeout_hit) timeout_err <= 1'b1;
            else if (clear_err)                               timeout_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vcu_insn_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vcu_insn_issuer
// Purpose  : Self-checking bench for vcu_insn_issuer. A transaction-level
//            reference (instruction queue plus phase of the in-flight
//            instruction) predicts every output each cycle; a small VCU
//            responder returns vcu_done after a chosen delay, or never.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vcu_insn_issuer;

    localparam int W  = 128;
    localparam int D  = 8;
    localparam int TW = 24;
    localparam int CW = 16;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  insn_in;
    logic          insn_in_valid;
    logic          insn_in_ready;
    logic          start;
    logic          flush;
    logic [TW-1:0] timeout_cycles;
    logic          clear_err;
    logic [W-1:0]  insn;
    logic          work_en;
    logic          vcu_done;
    logic          busy;
    logic [LW-1:0] level;
    logic [CW-1:0] done_cnt;
    logic          timeout_err;

    vcu_insn_issuer #(
        .INSN_WIDTH    (W),
        .DEPTH         (D),
        .TIMEOUT_WIDTH (TW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .insn_in        (insn_in),
        .insn_in_valid  (insn_in_valid),
        .insn_in_ready  (insn_in_ready),
        .start          (start),
        .flush          (flush),
        .timeout_cycles (timeout_cycles),
        .clear_err      (clear_err),
        .insn           (insn),
        .work_en        (work_en),
        .vcu_done       (vcu_done),
        .busy           (busy),
        .level          (level),
        .done_cnt       (done_cnt),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // ph: 0 = nothing in flight, 1 = loading, 2 = firing, 3 = waiting
    logic [W-1:0]  q[$];
    int            ph;
    int            wcnt;
    logic [W-1:0]  m_insn;
    logic [CW-1:0] m_cnt;
    bit            m_err;

    // VCU responder: mode 0 fixed delay, 1 random/never, 2 never
    int resp_mode, resp_delay, resp_cnt;
    bit noise_en;

    task automatic model_reset();
        q.delete();
        ph = 0; wcnt = 0; m_insn = '0; m_cnt = '0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_insn"},   insn,          m_insn);
        check_val({tag, "_work"},   work_en,       W'(ph == 2));
        check_val({tag, "_busy"},   busy,          W'(ph != 0));
        check_val({tag, "_level"},  level,         W'(q.size()));
        check_val({tag, "_ready"},  insn_in_ready, W'(q.size() < D && !flush));
        check_val({tag, "_cnt"},    done_cnt,      m_cnt);
        check_val({tag, "_err"},    timeout_err,   m_err);
    endtask

    // One clock: predict from the inputs present before the edge, then
    // compare after it and let the responder drive vcu_done.
    task automatic step(input string tag = "cyc");
        bit           go, push_ok, dn, fl, ce, hit;
        int           tmo;
        logic [W-1:0] din;
        din     = insn_in;
        dn      = vcu_done;
        fl      = flush;
        ce      = clear_err;
        tmo     = int'(timeout_cycles);
        push_ok = insn_in_valid && q.size() < D && !flush;
        go      = (ph == 0) && start && q.size() != 0 && !m_err && !flush;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (go)      m_insn = q.pop_front();
            if (push_ok) q.push_back(din);
        end
        hit = 0;
        case (ph)
            0: if (go) ph = 1;
            1: ph = 2;
            2: begin ph = 3; wcnt = 0; end
            default: begin
                wcnt++;
                if (dn) begin m_cnt++; ph = 0; end
                else if (tmo != 0 && wcnt == tmo) begin hit = 1; ph = 0; end
            end
        endcase
        if (hit)     m_err = 1;
        else if (ce) m_err = 0;
        check_all(tag);
        if (ph == 2) begin
            case (resp_mode)
                0:       resp_cnt = resp_delay;
                1:       resp_cnt = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 12));
                default: resp_cnt = -1;
            endcase
        end
        vcu_done = 1'b0;
        if (resp_cnt == 0) begin vcu_done = 1'b1; resp_cnt = -1; end
        else if (resp_cnt > 0) resp_cnt--;
        if (noise_en && $urandom_range(0, 19) == 0) vcu_done = 1'b1;
    endtask

    task automatic push_one(input logic [W-1:0] v);
        insn_in = v; insn_in_valid = 1'b1; step("push"); insn_in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy || level != 0) && n < budget) begin step("drain"); n++; end
        check_val("drain_idle", {busy, level}, '0);
    endtask

    function automatic logic [W-1:0] rnd_insn();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [W-1:0]  pushed [D];
    logic [W-1:0]  a1;
    logic [CW-1:0] base;
    int            lat, n, k;

    initial begin
        rst = 1'b1; insn_in = '0; insn_in_valid = 1'b0; start = 1'b0; flush = 1'b0;
        clear_err = 1'b0; vcu_done = 1'b0; timeout_cycles = '0;
        resp_mode = 0; resp_delay = 10; resp_cnt = -1; noise_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Single issue: three edges from push to the work_en cycle.
        a1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A1;
        start = 1'b1;
        push_one(a1);
        lat = 1;
        while (!work_en && lat < 10) begin step("single"); lat++; end
        check_val("single_latency", lat, 3);
        check_val("single_insn", insn, a1);
        drain(40);
        check_val("single_done_cnt", done_cnt, 1);

        // Fill to DEPTH with issuing disabled, then release.
        start = 1'b0; resp_delay = 2;
        for (int i = 0; i < D; i++) begin
            pushed[i] = rnd_insn();
            push_one(pushed[i]);
        end
        check_val("full_level", level, D);
        check_val("full_ready", insn_in_ready, 0);
        insn_in = rnd_insn(); insn_in_valid = 1'b1; step("ninth"); insn_in_valid = 1'b0;
        check_val("full_no_ninth", level, D);
        base = m_cnt; k = 0; n = 0; start = 1'b1;
        while ((busy || level != 0) && n < 200) begin
            step("full_issue"); n++;
            if (work_en) begin
                if (k < D) check_val("full_order", insn, pushed[k]);
                k++;
            end
        end
        check_val("full_issue_count", k, D);
        check_val("full_done_cnt", done_cnt, base + CW'(D));

        // Timeout with an unresponsive VCU.
        timeout_cycles = 5; resp_mode = 2; base = m_cnt;
        push_one(rnd_insn());
        push_one(rnd_insn());
        n = 0;
        while (!work_en && n < 10) begin step("tmo_fire"); n++; end
        n = 0;
        while (!timeout_err && n < 20) begin step("tmo_wait"); n++; end
        // n counts the FIRE->WAIT edge plus each WAIT cycle.
        check_val("tmo_wait_cycles", n - 1, 5);
        k = 0;
        for (int i = 0; i < 10; i++) begin step("tmo_hold"); if (work_en) k++; end
        check_val("tmo_no_issue", k, 0);
        check_val("tmo_level", level, 1);
        check_val("tmo_done_cnt", done_cnt, base);
        resp_mode = 0; resp_delay = 3;
        clear_err = 1'b1; step("clear"); clear_err = 1'b0;
        check_val("tmo_cleared", timeout_err, 0);
        n = 0;
        while (!work_en && n < 10) begin step("tmo_resume"); n++; end
        check_val("tmo_resume", work_en, 1);
        drain(40);
        check_val("tmo_resume_cnt", done_cnt, base + 1'b1);

        // vcu_done on the very cycle the budget runs out.
        resp_delay = 5; base = m_cnt;
        push_one(rnd_insn());
        drain(40);
        check_val("sim_done_cnt", done_cnt, base + 1'b1);
        check_val("sim_no_err", timeout_err, 0);

        // Push and pop on the same edge at level 3.
        start = 1'b0;
        for (int i = 0; i < 3; i++) push_one(rnd_insn());
        start = 1'b1; insn_in = rnd_insn(); insn_in_valid = 1'b1; step("pushpop"); insn_in_valid = 1'b0;
        check_val("pushpop_level", level, 3);
        drain(80);

        // Flush while an instruction is in WAIT.
        timeout_cycles = 0; resp_delay = 8; start = 1'b0; base = m_cnt;
        for (int i = 0; i < 5; i++) push_one(rnd_insn());
        start = 1'b1; n = 0;
        while (!work_en && n < 10) begin step("fl_fire"); n++; end
        step("fl_wait");
        check_val("flush_pre_level", level, 4);
        flush = 1'b1; step("flush"); flush = 1'b0;
        check_val("flush_level", level, 0);
        check_val("flush_inflight", busy, 1);
        drain(40);
        check_val("flush_done_cnt", done_cnt, base + 1'b1);
        k = 0;
        for (int i = 0; i < 10; i++) begin step("fl_after"); if (work_en) k++; end
        check_val("flush_no_issue", k, 0);

        // Asynchronous reset between edges during WAIT.
        resp_mode = 2;
        push_one(rnd_insn());
        push_one(rnd_insn());
        n = 0;
        while (!work_en && n < 10) begin step("ar_fire"); n++; end
        step("ar_wait");
        #2 rst = 1'b1;
        #1;
        check_val("arst_insn", insn, 0);
        check_val("arst_work", work_en, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_level", level, 0);
        check_val("arst_cnt", done_cnt, 0);
        check_val("arst_err", timeout_err, 0);
        check_val("arst_ready", insn_in_ready, 1);
        model_reset(); resp_cnt = -1; vcu_done = 1'b0;
        @(posedge clk);
        #1;
        check_val("arst_held_busy", busy, 0);
        rst = 1'b0;

        // Randomised traffic.
        resp_mode = 1; noise_en = 1; timeout_cycles = 6;
        for (int c = 0; c < 1500; c++) begin
            insn_in       = rnd_insn();
            insn_in_valid = ($urandom_range(0, 9) < 6);
            start         = ($urandom_range(0, 19) < 17);
            flush         = ($urandom_range(0, 39) == 0);
            clear_err     = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 49) == 0)
                timeout_cycles = ($urandom_range(0, 4) == 0) ? '0 : TW'($urandom_range(1, 15));
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
